// File: rtl/program_loader.sv
// program_loader: framed UART program loader and core-hold controller.
// Parses SYNC, LEN[7:0], LEN[15:8], LEN payload bytes, CSUM from the UART receiver,
// writes the payload into the byte-wide code store and releases the core once a
// checksum-clean image has been loaded.
//
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   rx_data     - received byte, qualified by rx_valid
//   rx_valid    - one-cycle strobe per received byte
//   code_we     - code store write enable (one cycle per payload byte)
//   code_waddr  - code store write address
//   code_wdata  - code store write data
//   core_hold   - 1 keeps the core in reset
//   busy        - 1 whenever the loader is not idle
//   load_done   - one-cycle pulse on an accepted image
//   load_error  - one-cycle pulse on a rejected frame
//   err_code    - sticky cause: 0 none, 1 bad length, 2 timeout, 3 checksum
//   image_len   - byte count of the last accepted image
//
// ADDR_WIDTH is assumed to be at most 16 (LEN is a 16-bit field).
module program_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  code_we,
  output logic [ADDR_WIDTH-1:0] code_waddr,
  output logic [7:0]            code_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   image_len
);

  localparam int unsigned       SilW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [SilW-1:0]   SilMax = SilW'(TIMEOUT_CYCLES - 1);
  localparam logic [SilW-1:0]   SilOne = SilW'(1);
  localparam logic [ADDR_WIDTH:0] IdxOne = (ADDR_WIDTH + 1)'(1);
  localparam logic [16:0]       MaxLen = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StCsum, StQuiet} state_e;

  state_e                state_q, state_d;
  logic [SilW-1:0]       sil_q, sil_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [7:0]            sum_q, sum_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [ADDR_WIDTH:0]   image_len_q, image_len_d;

  logic        timeout;
  logic        is_sync;
  logic [16:0] len17;
  logic        len_ok;
  logic        last_byte;
  logic        csum_ok;

  // A byte arriving in the limit cycle wins over the timeout.
  assign timeout   = !rx_valid && (sil_q == SilMax);
  assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
  assign len17     = {1'b0, rx_data, len_lo_q};
  assign len_ok    = (len17 != 17'd0) && (len17 <= MaxLen);
  // Index is one bit wider than the address so LEN = depth never wraps before CSUM.
  assign last_byte = (idx_q == (len_q - IdxOne));
  assign csum_ok   = ((sum_q + rx_data) == 8'd0);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sil_q       <= '0;
      len_lo_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      image_len_q <= '0;
    end else begin
      state_q     <= state_d;
      sil_q       <= sil_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      image_len_q <= image_len_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (is_sync) state_d = StLenLo;
      StLenLo: begin
        if (rx_valid)     state_d = StLenHi;
        else if (timeout) state_d = StIdle;
      end
      StLenHi: begin
        if (rx_valid)     state_d = len_ok ? StData : StQuiet;
        else if (timeout) state_d = StIdle;
      end
      StData: begin
        if (rx_valid && last_byte) state_d = StCsum;
        else if (timeout)          state_d = StIdle;
      end
      StCsum:  if (rx_valid || timeout) state_d = StIdle;
      StQuiet: if (timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    we_d        = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    err_code_d  = err_code_q;
    image_len_d = image_len_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;

    if (rx_valid || (state_d != state_q)) begin
      sil_d = '0;
    end else if (sil_q != SilMax) begin
      sil_d = sil_q + SilOne;
    end else begin
      sil_d = sil_q;
    end

    // Inter-byte timeout in any frame-parsing state; QUIET exits silently.
    if (timeout && (state_q inside {StLenLo, StLenHi, StData, StCsum})) begin
      err_d      = 1'b1;
      err_code_d = 2'd2;
    end

    unique case (state_q)
      StIdle: begin
        if (is_sync) begin
          hold_d     = 1'b1;
          err_code_d = 2'd0;
          idx_d      = '0;
          sum_d      = '0;
        end
      end
      StLenLo: if (rx_valid) len_lo_d = rx_data;
      StLenHi: begin
        if (rx_valid) begin
          if (len_ok) begin
            len_d = len17[ADDR_WIDTH:0];
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = idx_q[ADDR_WIDTH-1:0];
          wdata_d = rx_data;
          sum_d   = sum_q + rx_data;
          idx_d   = idx_q + IdxOne;
        end
      end
      StCsum: begin
        if (rx_valid) begin
          if (csum_ok) begin
            done_d      = 1'b1;
            image_len_d = len_q;
            hold_d      = 1'b0;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
          end
        end
      end
      StQuiet: ;
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign code_we    = we_q;
  assign code_waddr = waddr_q;
  assign code_wdata = wdata_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign load_error = err_q;
  assign err_code   = err_code_q;
  assign image_len  = image_len_q;

endmodule

// File: doc/program_loader.md
# program_loader

Framed UART program loader and core-hold controller for the code store. Consumes received bytes, validates a sync/length/payload/checksum frame, and sequences writes into the byte-wide code memory. Holds the processor core in reset until a complete, checksum-clean image has been loaded. Sits between the UART receiver and the code RAM write port, and drives the core's reset qualifier.

## Interface
Parameters:
- ADDR_WIDTH, 8, code store address width; depth = 2^ADDR_WIDTH bytes
- TIMEOUT_CYCLES, 10_000_000, inter-byte silence limit in clk cycles; must be ≥ 2
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte; valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- code_we  out  1  code store write enable, one cycle per payload byte
- code_waddr  out  ADDR_WIDTH  code store write address
- code_wdata  out  8  code store write data
- core_hold  out  1  1 = keep core in reset
- busy  out  1  1 whenever state ≠ IDLE
- load_done  out  1  one-cycle pulse on accepted image
- load_error  out  1  one-cycle pulse on rejected frame
- err_code  out  2  sticky cause: 0 none, 1 bad length, 2 timeout, 3 checksum
- image_len  out  ADDR_WIDTH+1  byte count of last accepted image

## Operation
- Frame: SYNC_BYTE, LEN[7:0], LEN[15:8], LEN payload bytes, CSUM. Valid when 1 ≤ LEN ≤ 2^ADDR_WIDTH and (sum of payload + CSUM) mod 256 = 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, QUIET.
- IDLE: rx_valid with SYNC_BYTE → LEN_LO; set core_hold=1; clear err_code; clear byte index and running sum. Other bytes are ignored, and core_hold is unchanged.
- LEN_LO → LEN_HI on a byte; LEN_HI → DATA on a byte if the 16-bit LEN is in range.
- If LEN is out of range (0 or > 2^ADDR_WIDTH): err_code=1, pulse load_error, → QUIET.
- DATA, per byte:
  - write the byte at the current index, starting from 0
  - add the byte to the 8-bit running sum
  - increment the index
  - after the LEN-th byte, → CSUM
- CSUM, on a byte:
  - Sum zero: pulse load_done, set image_len=LEN, core_hold=0, → IDLE.
  - Otherwise: err_code=3, pulse load_error, core_hold stays 1, → IDLE.
- Silence counter:
  - Resets to 0 on every rx_valid and on every state change; otherwise increments, saturating.
  - In LEN_LO..CSUM, reaching TIMEOUT_CYCLES−1 with no byte: err_code=2, pulse load_error, → IDLE, core_hold stays 1.
  - In QUIET, all bytes are ignored, including SYNC_BYTE. Reaching TIMEOUT_CYCLES−1 → IDLE. This avoids false sync on stale payload.
- The payload is written before the checksum is verified. Memory contents after a failed frame are undefined, but the core stays held.
- A new SYNC_BYTE in IDLE while the core is running re-asserts core_hold (reload).

## Timing
- Reset values: state=IDLE, core_hold=1, code_we=0, code_waddr=0, code_wdata=0, load_done=0, load_error=0, err_code=0, image_len=0, busy=0, silence counter=0.
- All outputs are registered except busy, which is decoded combinationally from state.
- rx_valid at cycle N:
  - Payload byte → code_we/code_waddr/code_wdata valid at N+1 for exactly one cycle.
  - SYNC in IDLE → core_hold=1 at N+1.
  - CSUM byte → load_done or load_error, core_hold change, and state=IDLE at N+1.
- Back-to-back rx_valid on consecutive cycles must be accepted with no loss. The write path has throughput of one byte per cycle.
- rx_valid in the same cycle the counter reaches its limit: the byte wins; no timeout.
- LEN = 2^ADDR_WIDTH: the last write is at address 2^ADDR_WIDTH−1, and the index does not wrap before CSUM.
- rst mid-frame: returns to reset values in the next cycle, and no further writes occur. Code store contents are not cleared.
- load_done and load_error are never asserted in the same cycle.

## Test plan
- Reset → core_hold=1, busy=0, err_code=0. Send frame A5 04 00 11 22 33 44 CSUM=0x56 →
  - writes (0,11), (1,22), (2,33), (3,44)
  - load_done pulse; core_hold=0; image_len=4
- Same frame with CSUM=0x57 → 4 writes, load_error pulse, err_code=3, core_hold=1.
- A5 00 00 → load_error, err_code=1. Then A5 arriving before the silence limit → ignored. Silence for TIMEOUT_CYCLES, then a valid frame → accepted.
- A5 02 00 7F, then silence of TIMEOUT_CYCLES → load_error, err_code=2, state IDLE, core_hold=1. The next valid frame loads.
- LEN=0x0100 with 256 back-to-back bytes 00..FF and CSUM=0x80 →
  - 256 consecutive writes, final address 0xFF
  - load_done; image_len=256
- After a successful load (core_hold=0), send 0x3C → ignored. Send A5 → core_hold=1 at the next cycle. Assert rst mid-payload → no further code_we; reset values restored.
